// File: rtl/div_pkg.sv
// Shared definitions for the sequential 32-bit divider: FSM state encoding,
// datapath widths, the divide-by-zero quotient and a conditional-negate helper.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH  = 32;
  localparam int ITER_CNT_W = 5;

  localparam logic [DIV_WIDTH-1:0] DIV0_QUOTIENT = 32'hFFFFFFFF;

  // Two's-complement negate when neg is set, pass-through otherwise.
  function automatic logic [DIV_WIDTH-1:0] cond_negate(input logic [DIV_WIDTH-1:0] v,
                                                       input logic neg);
    return neg ? (~v + DIV_WIDTH'(1)) : v;
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor over 33 bits, and keep the
// difference only when it did not go negative.
module div_step
  import div_pkg::*;
(
  input  logic [DIV_WIDTH-1:0] rem_i,
  input  logic                 dividend_bit_i,
  input  logic [DIV_WIDTH-1:0] divisor_i,
  output logic [DIV_WIDTH-1:0] rem_o,
  output logic                 q_bit_o
);

  logic [DIV_WIDTH:0] shifted;
  logic [DIV_WIDTH:0] trial;

  // Trial subtract; the borrow bit decides the quotient bit and whether to restore.
  always_comb begin
    shifted = {rem_i, dividend_bit_i};
    trial   = shifted - {1'b0, divisor_i};
    q_bit_o = ~trial[DIV_WIDTH];
    rem_o   = q_bit_o ? trial[DIV_WIDTH-1:0] : shifted[DIV_WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider32.sv
// Sequential 32-bit divider, one quotient bit per cycle (MSB first).
// A nonzero-divisor operation spends 32 cycles in CALC and pulses done in the
// following DONE cycle; a zero divisor goes straight to DONE.
// Optional signed division is enabled by defining SEQ_DIVIDER32_SIGNED_EN;
// without it the sgn input is ignored and every divide is unsigned.
import div_pkg::*;

module seq_divider32 (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DIV_WIDTH-1:0] dividend,
  input  logic [DIV_WIDTH-1:0] divisor,
  input  logic                 sgn,
  output logic                 busy,
  output logic                 done,
  output logic [DIV_WIDTH-1:0] quotient,
  output logic [DIV_WIDTH-1:0] remainder,
  output logic                 div_by_zero
);

  div_state_e state_q, state_d;

  logic [ITER_CNT_W-1:0] cnt_q, cnt_d;
  logic [DIV_WIDTH-1:0]  rem_q, rem_d;
  logic [DIV_WIDTH-1:0]  quo_q, quo_d;
  logic [DIV_WIDTH-1:0]  dvsr_q, dvsr_d;
  logic                  neg_quo_q, neg_quo_d;
  logic                  neg_rem_q, neg_rem_d;

  logic [DIV_WIDTH-1:0]  quotient_q, quotient_d;
  logic [DIV_WIDTH-1:0]  remainder_q, remainder_d;
  logic                  div_by_zero_q, div_by_zero_d;

  logic [DIV_WIDTH-1:0]  step_rem;
  logic                  step_bit;
  logic [DIV_WIDTH-1:0]  quo_final;
  logic                  eff_sgn;

`ifdef SEQ_DIVIDER32_SIGNED_EN
  assign eff_sgn = sgn;
`else
  logic unused_sgn;
  assign eff_sgn    = 1'b0;
  assign unused_sgn = sgn;
`endif

  div_step u_div_step (
    .rem_i          (rem_q),
    .dividend_bit_i (quo_q[DIV_WIDTH-1]),
    .divisor_i      (dvsr_q),
    .rem_o          (step_rem),
    .q_bit_o        (step_bit)
  );

  // State register, working registers and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      rem_q         <= '0;
      quo_q         <= '0;
      dvsr_q        <= '0;
      neg_quo_q     <= 1'b0;
      neg_rem_q     <= 1'b0;
      quotient_q    <= '0;
      remainder_q   <= '0;
      div_by_zero_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      rem_q         <= rem_d;
      quo_q         <= quo_d;
      dvsr_q        <= dvsr_d;
      neg_quo_q     <= neg_quo_d;
      neg_rem_q     <= neg_rem_d;
      quotient_q    <= quotient_d;
      remainder_q   <= remainder_d;
      div_by_zero_q <= div_by_zero_d;
    end
  end

  // Next-state logic: accept in IDLE, iterate in CALC, publish result on entry to DONE.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    rem_d         = rem_q;
    quo_d         = quo_q;
    dvsr_d        = dvsr_q;
    neg_quo_d     = neg_quo_q;
    neg_rem_d     = neg_rem_q;
    quotient_d    = quotient_q;
    remainder_d   = remainder_q;
    div_by_zero_d = div_by_zero_q;
    quo_final     = {quo_q[DIV_WIDTH-2:0], step_bit};

    case (state_q)
      IDLE: begin
        if (start) begin
          if (divisor == '0) begin
            state_d       = DONE;
            quotient_d    = DIV0_QUOTIENT;
            remainder_d   = dividend;
            div_by_zero_d = 1'b1;
          end else begin
            state_d       = CALC;
            cnt_d         = '0;
            rem_d         = '0;
            quo_d         = cond_negate(dividend, eff_sgn & dividend[DIV_WIDTH-1]);
            dvsr_d        = cond_negate(divisor, eff_sgn & divisor[DIV_WIDTH-1]);
            neg_quo_d     = eff_sgn & (dividend[DIV_WIDTH-1] ^ divisor[DIV_WIDTH-1]);
            neg_rem_d     = eff_sgn & dividend[DIV_WIDTH-1];
            div_by_zero_d = 1'b0;
          end
        end
      end
      CALC: begin
        rem_d = step_rem;
        quo_d = quo_final;
        cnt_d = cnt_q + ITER_CNT_W'(1);
        if (cnt_q == ITER_CNT_W'(DIV_WIDTH - 1)) begin
          state_d     = DONE;
          quotient_d  = cond_negate(quo_final, neg_quo_q);
          remainder_d = cond_negate(step_rem, neg_rem_q);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign busy        = (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quotient_q;
  assign remainder   = remainder_q;
  assign div_by_zero = div_by_zero_q;

endmodule

// File: tb/tb_seq_divider32.sv
// Self-checking bench for seq_divider32: directed vector table, hand-written
// back-to-back / held-start / mid-operation reset sequences, and randomized
// operations checked against a plain-arithmetic reference model.
// Signed expectations follow SEQ_DIVIDER32_SIGNED_EN.
module tb_seq_divider32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
  logic        sgn;
  logic        busy;
  logic        done;
  logic [31:0] quotient;
  logic [31:0] remainder;
  logic        div_by_zero;

  int checks = 0;
  int errors = 0;
  logic [31:0] prevQ = '0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        s;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  seq_divider32 dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .sgn         (sgn),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  // Free-running clock, 10 time-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain arithmetic, truncating toward zero for signed.
  function automatic void refDiv(input logic [31:0] a, input logic [31:0] b, input logic s,
                                 output logic [31:0] q, output logic [31:0] r,
                                 output logic dbz);
    dbz = (b == 32'd0);
    if (b == 32'd0) begin
      q = 32'hFFFFFFFF;
      r = a;
    end
`ifdef SEQ_DIVIDER32_SIGNED_EN
    else if (s) begin
      if (a == 32'h80000000 && b == 32'hFFFFFFFF) begin
        q = 32'h80000000;
        r = 32'd0;
      end else begin
        q = $signed(a) / $signed(b);
        r = $signed(a) % $signed(b);
      end
    end
`endif
    else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Single comparison with counting and failure report.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one operation from an IDLE negedge, follow it to done and check everything.
  // Returns at the negedge of the IDLE cycle after DONE, ready for a back-to-back start.
  task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic s,
                               input logic [31:0] eq, input logic [31:0] er,
                               input logic edbz, input string tag);
    int cyc;
    int busyCnt;
    int expLat;
    logic seen;
    expLat = (b == 32'd0) ? 1 : 33;
    dividend = a;
    divisor  = b;
    sgn      = s;
    start    = 1'b1;
    @(posedge clk);
    cyc = 1;
    busyCnt = 0;
    seen = 1'b0;
    while (cyc <= 40) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1 && b != 32'd0) begin
        checkOutput({tag, "_hold_q"}, quotient, prevQ);
        checkOutput({tag, "_dbz_clr"}, 32'(div_by_zero), 32'd0);
      end
      if (busy) busyCnt++;
      if (done) begin
        seen = 1'b1;
        break;
      end
      cyc++;
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    checkOutput({tag, "_q"}, quotient, eq);
    checkOutput({tag, "_r"}, remainder, er);
    checkOutput({tag, "_dbz"}, 32'(div_by_zero), 32'(edbz));
    checkOutput({tag, "_lat"}, 32'(cyc), 32'(expLat));
    checkOutput({tag, "_busy"}, 32'(busyCnt), 32'(expLat - 1));
    @(negedge clk);
    checkOutput({tag, "_pulse"}, 32'(done), 32'd0);
    checkOutput({tag, "_stable_r"}, remainder, er);
    prevQ = eq;
  endtask

  initial begin
    vec_t vecs[$];
    int doneCnt;
    int firstDone;
    int secondDone;
    logic [31:0] rq;
    logic [31:0] rr;
    logic        rdbz;
    logic [31:0] ra;
    logic [31:0] rb;
    logic        rs;

    vecs.push_back('{32'd100,       32'd7,          1'b0, 32'd14,        32'd2,         1'b0});
    vecs.push_back('{32'hFFFFFFFF,  32'd1,          1'b0, 32'hFFFFFFFF,  32'd0,         1'b0});
    vecs.push_back('{32'h12345678,  32'h10,         1'b0, 32'h01234567,  32'd8,         1'b0});
    vecs.push_back('{32'hDEADBEEF,  32'd0,          1'b0, 32'hFFFFFFFF,  32'hDEADBEEF,  1'b1});
    vecs.push_back('{32'd10,        32'd3,          1'b0, 32'd3,         32'd1,         1'b0});
    vecs.push_back('{32'd0,         32'd5,          1'b0, 32'd0,         32'd0,         1'b0});
    vecs.push_back('{32'd5,         32'd9,          1'b0, 32'd0,         32'd5,         1'b0});
    vecs.push_back('{32'hFFFFFFFF,  32'hFFFFFFFF,   1'b0, 32'd1,         32'd0,         1'b0});
    vecs.push_back('{32'h7FFFFFFF,  32'h80000000,   1'b0, 32'd0,         32'h7FFFFFFF,  1'b0});
`ifdef SEQ_DIVIDER32_SIGNED_EN
    vecs.push_back('{32'hFFFFFFF9,  32'd2,          1'b1, 32'hFFFFFFFD,  32'hFFFFFFFF,  1'b0});
    vecs.push_back('{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'h80000000,  32'd0,         1'b0});
    vecs.push_back('{32'd7,         32'hFFFFFFFE,   1'b1, 32'hFFFFFFFD,  32'd1,         1'b0});
`else
    vecs.push_back('{32'hFFFFFFF9,  32'd2,          1'b1, 32'h7FFFFFFC,  32'd1,         1'b0});
    vecs.push_back('{32'h80000000,  32'hFFFFFFFF,   1'b1, 32'd0,         32'h80000000,  1'b0});
`endif

    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    sgn = 1'b0;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_done", 32'(done), 32'd0);
    checkOutput("reset_q", quotient, 32'd0);
    checkOutput("reset_r", remainder, 32'd0);
    checkOutput("reset_dbz", 32'(div_by_zero), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] directed vector table");
    foreach (vecs[i])
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].s, vecs[i].q, vecs[i].r, vecs[i].dbz,
                    $sformatf("vec%0d", i));

    $display("[TB] divide-by-zero result holds while idle");
    applyStimulus(32'hCAFEF00D, 32'd0, 1'b0, 32'hFFFFFFFF, 32'hCAFEF00D, 1'b1, "div0_hold");
    repeat (5) @(negedge clk);
    checkOutput("div0_idle_dbz", 32'(div_by_zero), 32'd1);
    checkOutput("div0_idle_r", remainder, 32'hCAFEF00D);

    $display("[TB] start held high through two operations");
    dividend = 32'd100;
    divisor = 32'd7;
    sgn = 1'b0;
    start = 1'b1;
    doneCnt = 0;
    firstDone = 0;
    secondDone = 0;
    for (int i = 1; i <= 70; i++) begin
      @(negedge clk);
      if (i == 40) start = 1'b0;
      if (i == 34) checkOutput("held_idle_gap", 32'(busy), 32'd0);
      if (i == 35) checkOutput("held_reaccept", 32'(busy), 32'd1);
      if (done) begin
        doneCnt++;
        if (doneCnt == 1) firstDone = i;
        else if (doneCnt == 2) secondDone = i;
      end
    end
    checkOutput("held_done_count", 32'(doneCnt), 32'd2);
    checkOutput("held_first_done", 32'(firstDone), 32'd33);
    checkOutput("held_second_done", 32'(secondDone), 32'd67);
    checkOutput("held_q", quotient, 32'd14);
    checkOutput("held_r", remainder, 32'd2);
    prevQ = 32'd14;

    $display("[TB] reset in the middle of a calculation");
    dividend = 32'd1000;
    divisor = 32'd3;
    start = 1'b1;
    @(posedge clk);
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checkOutput("midrst_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    start = 1'b1;
    #1;
    checkOutput("midrst_busy", 32'(busy), 32'd0);
    checkOutput("midrst_done", 32'(done), 32'd0);
    checkOutput("midrst_q", quotient, 32'd0);
    checkOutput("midrst_r", remainder, 32'd0);
    checkOutput("midrst_dbz", 32'(div_by_zero), 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("rst_blocks_start", 32'(busy), 32'd0);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    doneCnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done || busy) doneCnt++;
    end
    checkOutput("midrst_no_done", 32'(doneCnt), 32'd0);
    prevQ = 32'd0;
    applyStimulus(32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 1'b0, "after_rst");

    $display("[TB] randomized operations");
    for (int n = 0; n < 25; n++) begin
      ra = $urandom;
      rs = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'($urandom_range(1, 15));
        2: rb = $urandom;
        3: rb = 32'hFFFFFFFF;
        default: begin
          ra = 32'h80000000;
          rb = $urandom;
        end
      endcase
      refDiv(ra, rb, rs, rq, rr, rdbz);
      applyStimulus(ra, rb, rs, rq, rr, rdbz, $sformatf("rand%0d", n));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_divider32.md
SEQ_DIVIDER32 -- requirements
Module: seq_divider32

Interface
REQ-001 SHALL have port clk, input, 1 bit: single rising-edge clock for all state.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-003 SHALL have port start, input, 1 bit: request a divide; sampled only in IDLE.
REQ-004 SHALL have port dividend, input, 32 bits: numerator, captured on the accepted start.
REQ-005 SHALL have port divisor, input, 32 bits: denominator, captured on the accepted start.
REQ-006 SHALL have port sgn, input, 1 bit: 1 = signed two's-complement divide, 0 = unsigned; captured on the accepted start.
REQ-007 SHALL have port busy, output, 1 bit: high while in CALC.
REQ-008 SHALL have port done, output, 1 bit: one-cycle pulse when the result is valid.
REQ-009 SHALL have port quotient, output, 32 bits: result quotient.
REQ-010 SHALL have port remainder, output, 32 bits: result remainder.
REQ-011 SHALL have port div_by_zero, output, 1 bit: flags that the last accepted divisor was 0.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, DONE.
REQ-013 SHALL leave IDLE for CALC on a rising edge where start=1 and divisor!=0, and capture dividend, divisor and sgn on that edge.
REQ-014 SHALL perform restoring shift-subtract with a 33-bit partial remainder, one quotient bit per cycle, MSB first.
REQ-015 SHALL keep CALC for exactly 32 cycles, then enter DONE; done=1 for the single DONE cycle, which is the 33rd cycle after the accepting edge.
REQ-016 SHALL return from DONE to IDLE unconditionally after one cycle.
REQ-017 SHALL ignore start in CALC and DONE: no queueing and no change of the operation in progress.
REQ-018 SHALL go IDLE->DONE directly when start=1 and divisor=0, with quotient=0xFFFFFFFF, remainder=dividend, div_by_zero=1 and done asserted on the next cycle.
REQ-019 SHALL clear div_by_zero on the next accepted start whose divisor is nonzero.
REQ-020 SHALL hold quotient, remainder and div_by_zero stable from DONE until the next accepted start.
REQ-021 SHALL accept a start issued in the IDLE cycle immediately following DONE (back-to-back operation).
REQ-022 SHALL leave quotient and remainder unchanged until DONE of a new operation; internal working registers SHALL be separate from the output registers.

Reset
REQ-023 SHALL on rst=1 (asynchronous) force IDLE, busy=0, done=0, quotient=0, remainder=0, div_by_zero=0.
REQ-024 SHALL abort any in-progress operation on mid-operation reset, with no done pulse for the aborted operation.
REQ-025 SHALL not accept start while rst=1.

Configuration
REQ-026 SHALL support signed division only when macro SEQ_DIVIDER32_SIGNED_EN is defined.
REQ-027 SHALL, with SEQ_DIVIDER32_SIGNED_EN defined and sgn=1:
- take operand magnitudes at start;
- negate the quotient when the operand signs differ;
- give the remainder the dividend's sign (truncation toward zero);
- apply sign correction in the DONE cycle with latency unchanged;
- return quotient=0x80000000, remainder=0 for 0x80000000 / 0xFFFFFFFF;
- return remainder=dividend for divide by zero.
REQ-028 SHALL, without SEQ_DIVIDER32_SIGNED_EN, ignore sgn and always divide unsigned.

Structure
REQ-029 SHALL place the state enum (IDLE/CALC/DONE), DIV_WIDTH=32, ITER_CNT_W=5 and DIV0_QUOTIENT=32'hFFFFFFFF in shared package div_pkg.
REQ-030 SHALL instantiate one combinational sub-module, div_step: 33-bit trial subtract of the shifted remainder, producing the next remainder and the quotient bit.

Verification
REQ-031 SHALL cover unsigned 100 / 7 -> quotient=14, remainder=2, done exactly 33 cycles after start, busy high for 32 cycles.
REQ-032 SHALL cover 0xFFFFFFFF / 1 -> quotient=0xFFFFFFFF, remainder=0; then back-to-back 0x12345678 / 0x10 -> quotient=0x01234567, remainder=8.
REQ-033 SHALL cover 0xDEADBEEF / 0 -> done next cycle, quotient=0xFFFFFFFF, remainder=0xDEADBEEF, div_by_zero=1; then 10 / 3 -> div_by_zero=0, quotient=3, remainder=1.
REQ-034 SHALL cover, with SEQ_DIVIDER32_SIGNED_EN and sgn=1:
- 0xFFFFFFF9 / 2 -> quotient=0xFFFFFFFD, remainder=0xFFFFFFFF;
- 0x80000000 / 0xFFFFFFFF -> quotient=0x80000000, remainder=0.
REQ-035 SHALL cover rst pulsed 10 cycles into CALC -> immediate IDLE, all outputs 0, no done; a new 9 / 4 then gives quotient=2, remainder=1.
REQ-036 SHALL cover start held high through an entire operation -> exactly one done per accepted start, and the second accept occurs in the IDLE cycle after DONE.
